// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder: chunk geometry and the parameter legality check.
package adder_pkg;

  function automatic int chunk_w(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  function automatic int chunk_lo(input int k, input int chunk);
    return k * chunk;
  endfunction

  // Bits actually covered by stage k; a stage past the top bit covers nothing.
  function automatic int chunk_len(input int k, input int chunk, input int width);
    int lo;
    lo = chunk_lo(k, chunk);
    if (lo >= width) return 0;
    return (width - lo < chunk) ? (width - lo) : chunk;
  endfunction

  function automatic bit params_legal(input int width, input int stages);
    return (width >= 1) && (stages >= 1) && (stages <= width);
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One pipeline stage: adds its chunk with the incoming carry and forwards the
// operand/result shift registers and its valid bit when allowed to advance.
module adder_pipe_stage #(
  parameter int WIDTH = 18,
  parameter int LO    = 0,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_a,
  input  logic [WIDTH-1:0] prev_b,
  input  logic [WIDTH-1:0] prev_res,
  input  logic             prev_carry,
  output logic             valid,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] res_q,
  output logic             carry_q
);

  logic [WIDTH-1:0] res_next;
  logic             carry_next;

  if (CW > 0) begin : g_add
    logic [CW:0] chunk_sum;
    always_comb begin
      // NOTE: every always_comb output gets a full default first so no latch is inferred.
      res_next             = prev_res;
      chunk_sum            = {1'b0, prev_a[LO +: CW]} + {1'b0, prev_b[LO +: CW]}
                             + {{CW{1'b0}}, prev_carry};
      res_next[LO +: CW]   = chunk_sum[CW-1:0];
      carry_next           = chunk_sum[CW];
    end
  end else begin : g_pass
    assign res_next   = prev_res;
    assign carry_next = prev_carry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: data registers are reset too, because sum must read 0 straight out of reset.
    if (!rst_n) begin
      valid   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else if (advance) begin
      valid <= prev_valid;
      if (prev_valid) begin
        a_q     <= prev_a;
        b_q     <= prev_b;
        res_q   <= res_next;
        carry_q <= carry_next;
      end
    end
  end

endmodule

// File: rtl/pipelined_adder_nbit.sv
// Pipelined ripple-carry adder/subtractor with valid/ready backpressure.
// Define ADDER_OVF_EN to add the signed-overflow output ovf.
module pipelined_adder_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH  = 18,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_adder_nbit: need WIDTH >= 1 and 1 <= STAGES <= WIDTH");
  end

  // Index 0 is the prepared input; index k+1 is the output of stage k.
  logic [WIDTH-1:0] a_pipe   [STAGES+1];
  logic [WIDTH-1:0] b_pipe   [STAGES+1];
  logic [WIDTH-1:0] res_pipe [STAGES+1];
  logic [STAGES:0]  carry_pipe;
  logic [STAGES:0]  valid_pipe;
  logic [STAGES:0]  ready;

  // Subtract as a + ~b + !c_in, so later stages only ever add.
  assign a_pipe[0]     = a;
  assign b_pipe[0]     = sub ? ~b : b;
  assign res_pipe[0]   = '0;
  assign carry_pipe[0] = c_in ^ sub;
  assign valid_pipe[0] = in_valid;

  assign ready[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = chunk_lo(k, CHUNK);
    localparam int CW = chunk_len(k, CHUNK, WIDTH);

    assign ready[k] = !valid_pipe[k+1] || ready[k+1];

    adder_pipe_stage #(
      .WIDTH (WIDTH),
      .LO    (LO),
      .CW    (CW)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .advance    (ready[k]),
      .prev_valid (valid_pipe[k]),
      .prev_a     (a_pipe[k]),
      .prev_b     (b_pipe[k]),
      .prev_res   (res_pipe[k]),
      .prev_carry (carry_pipe[k]),
      .valid      (valid_pipe[k+1]),
      .a_q        (a_pipe[k+1]),
      .b_q        (b_pipe[k+1]),
      .res_q      (res_pipe[k+1]),
      .carry_q    (carry_pipe[k+1])
    );
  end

  assign in_ready  = ready[0];
  assign out_valid = valid_pipe[STAGES];
  assign sum       = {carry_pipe[STAGES], res_pipe[STAGES]};

`ifdef ADDER_OVF_EN
  // Built only from last-stage registers, so it holds with sum during a stall.
  assign ovf = (a_pipe[STAGES][WIDTH-1] ^ b_pipe[STAGES][WIDTH-1] ^ 1'b1)
             & (a_pipe[STAGES][WIDTH-1] ^ res_pipe[STAGES][WIDTH-1]);
`endif

endmodule
